// File: rtl/passive_alarm_fsm.sv
// passive_alarm_fsm: passive-vehicle alarm. It alerts when the headlights are on,
// a door is open and the ignition is off, once that condition has held for
// DEB_CYCLES consecutive cycles. While in ALERT it drives a chime pulse train.
// The driver can silence it with Ack. It also records which doors were open
// during the episode and keeps a saturating count of episodes.
// Optional feature: define PASSIVE_ALARM_TIMEOUT_EN so that an unacknowledged
// alert silences itself after TIMEOUT_CYCLES cycles in ALERT. The port list is
// the same in both builds.
module passive_alarm_fsm #(
    parameter int N_DOORS        = 4,
    parameter int DEB_CYCLES     = 8,
    parameter int CHIME_HALF     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               CarLightsOnSign,
    input  logic [N_DOORS-1:0] OpenDoorSign,
    input  logic               IgnitionSignalOn,
    input  logic               Ack,
    output logic               PassiveSignal,
    output logic               Chime,
    output logic [N_DOORS-1:0] DoorMask,
    output logic [CNT_W-1:0]   AlarmCount
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUAL     = 2'd1,
        ALERT    = 2'd2,
        SILENCED = 2'd3
    } state_t;

    localparam logic [7:0]  QUAL_LAST  = 8'(DEB_CYCLES - 1);
    localparam logic [7:0]  CHIME_LAST = 8'(CHIME_HALF - 1);
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    // Reject out-of-range configurations at elaboration time.
    if (N_DOORS < 1 || N_DOORS > 8 || DEB_CYCLES < 1 || DEB_CYCLES > 255 ||
        CHIME_HALF < 1 || CHIME_HALF > 255 || TIMEOUT_CYCLES < 1 ||
        TIMEOUT_CYCLES > 65535 || CNT_W < 1) begin : g_bad_params
        $error("passive_alarm_fsm: parameter out of legal range");
    end

    logic               r_lights;
    logic [N_DOORS-1:0] r_doors;
    logic               r_ign;
    logic               r_ack;
    logic               w_cond;

    state_t             r_state;
    logic [7:0]         r_qual_cnt;
    logic [7:0]         r_chime_cnt;
`ifdef PASSIVE_ALARM_TIMEOUT_EN
    logic [15:0]        r_tmo_cnt;
`endif

    // Sample stage: register every asynchronous car input once before use.
    // NOTE: sequential state uses non-blocking (<=) assignments only. This keeps
    // every flop updating from pre-edge values, with no ordering races.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_lights <= 1'b0;
            r_doors  <= '0;
            r_ign    <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_lights <= CarLightsOnSign;
            r_doors  <= OpenDoorSign;
            r_ign    <= IgnitionSignalOn;
            r_ack    <= Ack;
        end
    end

    // Alarm condition, built from sampled inputs only.
    assign w_cond = r_lights & (|r_doors) & ~r_ign;

    // Alarm FSM with its counters and all registered outputs.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state       <= IDLE;
            r_qual_cnt    <= '0;
            r_chime_cnt   <= '0;
`ifdef PASSIVE_ALARM_TIMEOUT_EN
            r_tmo_cnt     <= '0;
`endif
            PassiveSignal <= 1'b0;
            Chime         <= 1'b0;
            DoorMask      <= '0;
            AlarmCount    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cond) begin
                        r_state    <= QUAL;
                        r_qual_cnt <= '0;
                    end
                end
                QUAL: begin
                    if (!w_cond) begin
                        r_state <= IDLE;
                    end else if (r_qual_cnt == QUAL_LAST) begin
                        r_state       <= ALERT;
                        PassiveSignal <= 1'b1;
                        Chime         <= 1'b1;
                        r_chime_cnt   <= '0;
`ifdef PASSIVE_ALARM_TIMEOUT_EN
                        r_tmo_cnt     <= '0;
`endif
                        DoorMask      <= r_doors;
                        if (AlarmCount != {CNT_W{1'b1}})
                            AlarmCount <= AlarmCount + 1'b1;
                    end else begin
                        r_qual_cnt <= r_qual_cnt + 8'd1;
                    end
                end
                ALERT: begin
                    if (!w_cond) begin
                        r_state       <= IDLE;
                        PassiveSignal <= 1'b0;
                        Chime         <= 1'b0;
                        DoorMask      <= '0;
                    end else if (r_ack) begin
                        r_state  <= SILENCED;
                        Chime    <= 1'b0;
                        DoorMask <= DoorMask | r_doors;
`ifdef PASSIVE_ALARM_TIMEOUT_EN
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_state  <= SILENCED;
                        Chime    <= 1'b0;
                        DoorMask <= DoorMask | r_doors;
`endif
                    end else begin
`ifdef PASSIVE_ALARM_TIMEOUT_EN
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
`endif
                        DoorMask <= DoorMask | r_doors;
                        if (r_chime_cnt == CHIME_LAST) begin
                            Chime       <= ~Chime;
                            r_chime_cnt <= '0;
                        end else begin
                            r_chime_cnt <= r_chime_cnt + 8'd1;
                        end
                    end
                end
                SILENCED: begin
                    if (!w_cond) begin
                        r_state       <= IDLE;
                        PassiveSignal <= 1'b0;
                        DoorMask      <= '0;
                    end else begin
                        DoorMask <= DoorMask | r_doors;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    PassiveSignal <= 1'b0;
                    Chime         <= 1'b0;
                    DoorMask      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_passive_alarm_fsm.sv
// Directed bench for passive_alarm_fsm. There are two instances: one with
// default parameters and one with CNT_W=2. Both are driven by the same
// stimulus, with TIMEOUT_CYCLES=16. Expected values are hand-computed from
// edge counts. E0 is the first edge that samples a new input pattern.
module tb_passive_alarm_fsm;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       lights;
    logic [3:0] doors;
    logic       ign;
    logic       ack;

    logic       p1, c1;
    logic [3:0] m1;
    logic [7:0] a1;
    logic       p2, c2;
    logic [3:0] m2;
    logic [1:0] a2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    passive_alarm_fsm #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_L(reset_L), .CarLightsOnSign(lights),
        .OpenDoorSign(doors), .IgnitionSignalOn(ign), .Ack(ack),
        .PassiveSignal(p1), .Chime(c1), .DoorMask(m1), .AlarmCount(a1)
    );

    passive_alarm_fsm #(.TIMEOUT_CYCLES(16), .CNT_W(2)) dut_c2 (
        .clk(clk), .reset_L(reset_L), .CarLightsOnSign(lights),
        .OpenDoorSign(doors), .IgnitionSignalOn(ign), .Ack(ack),
        .PassiveSignal(p2), .Chime(c2), .DoorMask(m2), .AlarmCount(a2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_passive"}, 32'(p1), 32'd0);
        check({tag, "_chime"},   32'(c1), 32'd0);
        check({tag, "_mask"},    32'(m1), 32'd0);
        check({tag, "_count"},   32'(a1), 32'd0);
        check({tag, "_c2_pass"}, 32'(p2), 32'd0);
        check({tag, "_c2_cnt"},  32'(a2), 32'd0);
    endtask

    initial begin
        reset_L = 1'b0;
        lights  = 1'b0;
        doors   = 4'b0000;
        ign     = 1'b0;
        ack     = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        reset_L = 1'b1;

        // Episode 1: lights on, door 1 open, ignition off.
        lights = 1'b1;
        doors  = 4'b0010;
        tick(9);                                    // after E8
        check("ep1_pre_passive", 32'(p1), 32'd0);
        check("ep1_pre_count",   32'(a1), 32'd0);
        tick(1);                                    // after E9
        check("ep1_passive", 32'(p1), 32'd1);
        check("ep1_chime",   32'(c1), 32'd1);
        check("ep1_mask",    32'(m1), 32'b0010);
        check("ep1_count",   32'(a1), 32'd1);
        check("ep1_c2_count", 32'(a2), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check("ep1_chime_seq", 32'(c1), ((k % 8) < 4) ? 32'd1 : 32'd0);
        end

        // Acknowledge for one cycle, which silences the alert.
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(1);
        check("sil_chime",   32'(c1), 32'd0);
        check("sil_passive", 32'(p1), 32'd1);
        doors = 4'b1010;
        tick(2);
        check("sil_mask", 32'(m1), 32'b1010);
        doors = 4'b0000;
        tick(2);
        check("close_passive", 32'(p1), 32'd0);
        check("close_mask",    32'(m1), 32'd0);

        // Episode 2: a one-cycle ignition blip during qualification restarts it.
        doors = 4'b0010;
        tick(5);
        ign = 1'b1;
        tick(1);
        ign = 1'b0;
        tick(9);
        check("blip_pre_passive", 32'(p1), 32'd0);
        check("blip_pre_count",   32'(a1), 32'd1);
        tick(1);
        check("blip_passive", 32'(p1), 32'd1);
        check("blip_count",   32'(a1), 32'd2);
        check("blip_c2_count", 32'(a2), 32'd2);

        // Ack and ignition sampled together: the condition drop wins, so the FSM goes to IDLE.
        ack = 1'b1;
        ign = 1'b1;
        tick(1);
        ack = 1'b0;
        ign = 1'b0;
        tick(1);
        check("prio_passive", 32'(p1), 32'd0);
        check("prio_chime",   32'(c1), 32'd0);
        check("prio_mask",    32'(m1), 32'd0);
        // Episode 3 starts from the edge that just sampled ign=0.
        tick(8);
        check("ep3_pre_passive", 32'(p1), 32'd0);
        tick(1);
        check("ep3_passive",  32'(p1), 32'd1);
        check("ep3_count",    32'(a1), 32'd3);
        check("ep3_c2_count", 32'(a2), 32'd3);

        // Episode 4: the 2-bit count saturates.
        lights = 1'b0;
        tick(2);
        check("ep4_idle_passive", 32'(p1), 32'd0);
        lights = 1'b1;
        tick(10);
        check("ep4_passive",  32'(p1), 32'd1);
        check("ep4_count",    32'(a1), 32'd4);
        check("ep4_c2_count", 32'(a2), 32'd3);

        // Long unacknowledged alert: check the chime, or the timeout when it is enabled.
        tick(8);                                    // 8 alert cycles after entry
        check("long_chime_k8", 32'(c1), 32'd1);
        tick(8);                                    // k = 16
`ifdef PASSIVE_ALARM_TIMEOUT_EN
        check("tmo_chime_k16", 32'(c1), 32'd0);
`else
        check("long_chime_k16", 32'(c1), 32'd1);
`endif
        check("long_passive_k16", 32'(p1), 32'd1);
        tick(83);                                   // k = 99
`ifdef PASSIVE_ALARM_TIMEOUT_EN
        check("tmo_chime_k99", 32'(c1), 32'd0);
`else
        check("long_chime_k99", 32'(c1), 32'd1);
`endif
        tick(1);                                    // k = 100
        check("long_chime_k100", 32'(c1), 32'd0);
        check("long_passive_k100", 32'(p1), 32'd1);

        // Asynchronous reset mid-alert: outputs clear with no clock edge.
        reset_L = 1'b0;
        #2;
        check_zero("async_rst");
        #2;
        reset_L = 1'b1;
        // Inputs are still asserted, so a full requalification is required.
        tick(9);
        check("rq_pre_passive", 32'(p1), 32'd0);
        tick(1);
        check("rq_passive", 32'(p1), 32'd1);
        check("rq_count",   32'(a1), 32'd1);
        check("rq_mask",    32'(m1), 32'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/passive_alarm_fsm.md
PASSIVE_ALARM_FSM -- requirements
Module: passive_alarm_fsm

Interface
REQ-001 Parameter N_DOORS, default 4, number of door-open inputs; legal range 1..8.
REQ-002 Parameter DEB_CYCLES, default 8, number of consecutive qualifying cycles required before alert; legal range 1..255.
REQ-003 Parameter CHIME_HALF, default 4, Chime half-period in clock cycles; legal range 1..255.
REQ-004 Parameter TIMEOUT_CYCLES, default 64, alert auto-silence time in cycles; used only with the macro in REQ-030; legal range 1..65535.
REQ-005 Parameter CNT_W, default 8, width of AlarmCount.
REQ-006 clk  input  1  single system clock; all state updates on rising edge.
REQ-007 reset_L  input  1  asynchronous, active-low reset.
REQ-008 CarLightsOnSign  input  1  headlights on.
REQ-009 OpenDoorSign  input  N_DOORS  bit i high = door i open.
REQ-010 IgnitionSignalOn  input  1  ignition on.
REQ-011 Ack  input  1  driver acknowledge; level, sampled each cycle.
REQ-012 PassiveSignal  output  1  registered; alarm condition qualified and not cleared.
REQ-013 Chime  output  1  registered; audible pulse train.
REQ-014 DoorMask  output  N_DOORS  registered; doors seen open during the current alarm episode.
REQ-015 AlarmCount  output  CNT_W  registered; saturating count of alarm episodes.

Function
REQ-016 All inputs except clk/reset_L SHALL be registered once (sample stage) before use; cond_r = lights_r AND (OR of doors_r) AND NOT ign_r.
REQ-017 FSM states SHALL be IDLE, QUAL, ALERT, SILENCED.
REQ-018 IDLE: cond_r=1 -> QUAL with qualification counter = 0; else stay.
REQ-019 QUAL: cond_r=0 -> IDLE; cond_r=1 and counter = DEB_CYCLES-1 -> ALERT; otherwise counter increments.
REQ-020 Latency: inputs meeting the condition continuously from sampling edge E0 SHALL cause PassiveSignal=1 after edge E0+DEB_CYCLES+1 (E0+9 at defaults).
REQ-021 ALERT: cond_r=0 -> IDLE; else Ack_r=1 -> SILENCED; else stay; cond_r=0 has priority over Ack_r.
REQ-022 SILENCED: cond_r=0 -> IDLE; Ack_r has no effect.
REQ-023 PassiveSignal SHALL be 1 exactly while state is ALERT or SILENCED.
REQ-024 Chime SHALL be 1 on the first ALERT cycle and toggle every CHIME_HALF cycles while in ALERT; 0 in all other states; the chime phase counter restarts on every ALERT entry.
REQ-025 On ALERT entry, DoorMask SHALL load doors_r; in ALERT/SILENCED it SHALL OR in doors_r each cycle; on transition to IDLE it SHALL clear to 0.
REQ-026 AlarmCount SHALL increment by 1 on each QUAL->ALERT transition and saturate at 2^CNT_W-1 (no wrap).
REQ-027 A momentary cond_r drop of a single cycle in QUAL SHALL restart qualification from IDLE (no hysteresis).

Reset
REQ-028 reset_L=0 SHALL asynchronously force state IDLE, all counters and sample registers 0, PassiveSignal=0, Chime=0, DoorMask=0, AlarmCount=0.
REQ-029 Reset asserted mid-ALERT SHALL clear outputs immediately; after release, a new alert SHALL require full DEB_CYCLES requalification.

Configuration
REQ-030 Macro PASSIVE_ALARM_TIMEOUT_EN defined: ALERT with cond_r=1 and no Ack_r SHALL move to SILENCED after TIMEOUT_CYCLES consecutive ALERT cycles; the timeout counter resets on each ALERT entry.
REQ-031 Macro undefined: no timeout logic; ALERT persists until Ack_r or cond_r=0; TIMEOUT_CYCLES ignored; port list identical in both builds.

Verification
REQ-032 Defaults; lights=1, doors=4'b0010, ign=0 held -> PassiveSignal rises after edge E0+9, Chime=1,1,1,1,0,0,0,0,1..., DoorMask=4'b0010, AlarmCount=1.
REQ-033 Condition held 5 cycles then ign=1 for 1 cycle, then condition again -> no alert until 9 edges after reapplication; AlarmCount unchanged until then.
REQ-034 In ALERT, Ack=1 one cycle -> SILENCED: Chime=0, PassiveSignal=1; then door 3 opens -> DoorMask=4'b1010; then all doors close -> IDLE, PassiveSignal=0, DoorMask=0.
REQ-035 Ack=1 and ign=1 sampled in the same cycle during ALERT -> IDLE (not SILENCED).
REQ-036 CNT_W=2, four alarm episodes -> AlarmCount 1,2,3,3.
REQ-037 PASSIVE_ALARM_TIMEOUT_EN, TIMEOUT_CYCLES=16, no Ack -> SILENCED after 16 ALERT cycles, Chime=0; without macro Chime still toggling at cycle 100; reset_L=0 mid-ALERT -> all outputs 0 without a clock edge.
